console_uart_tx: RTL and testbench
==================================

# console_uart_tx

Memory-mapped console output peripheral for the picorv32 native memory bus. It decodes CPU stores to the console data address and buffers the characters in a FIFO. A serializer then drives them out as 8N1 UART frames, and a status register can be read back. It sits beside the main RAM model on the same `mem_*` bus, replacing the simulation-only `$write` console sink with synthesizable logic.

## Interface
Parameters:
- `ADDR_DATA`, default `32'h1000_0000`: console data register (write pushes a char; read returns 0).
- `ADDR_STAT`, default `32'h1000_0004`: status register (read-only; writes are acked and ignored).
- `CLK_DIV`, default 16: clk cycles per UART bit, ≥2.
- `FIFO_DEPTH`, default 16: character FIFO depth, power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `mem_valid` in 1: CPU request valid.
- `mem_addr` in 32: request address.
- `mem_wdata` in 32: write data; only `[7:0]` is used.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `sel` out 1: combinational, `mem_valid && (mem_addr==ADDR_DATA || mem_addr==ADDR_STAT)`. Used by the bus mux.
- `mem_ready` out 1: registered one-cycle acknowledge.
- `mem_rdata` out 32: registered read data, valid while `mem_ready`=1.
- `uart_tx` out 1: serial output, idle high.
- `busy` out 1: FIFO non-empty or frame in progress.

## Operation
- **Accept condition:** `sel && !mem_ready`. A request is accepted unless it is a data write with FIFO full and no pop this cycle. When a request is accepted, `mem_ready` is 1 in the next cycle, then returns to 0.
- **Data write, `wstrb[0]`=1:** push `wdata[7:0]`.
- **Data write, `wstrb[0]`=0:** ack only, no push.
- **Reads:**
  - Data read returns 0.
  - Stat read returns: `[0]` full, `[1]` empty, `[2]` shifter active, `[15:8]` FIFO count, all other bits 0.
- **Full-FIFO stall:** a data write with FIFO full holds `mem_ready` low until a pop frees space.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A stalled write is accepted in the same cycle as the pop.
- **Serializer FSM:** states IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into an 8-bit shift register and go to START.
  - START: `uart_tx`=0 for `CLK_DIV` cycles.
  - DATA: 8 bits, LSB first, `CLK_DIV` cycles each. A 3-bit bit counter wraps 7→0 on exit.
  - STOP: `uart_tx`=1 for `CLK_DIV` cycles. At the end of STOP, if FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - The baud counter is a $clog2(CLK_DIV)-bit down-counter. It reloads `CLK_DIV-1` on every state or bit change.
- **FIFO count width:** FIFO pointers are wrap-around `$clog2(FIFO_DEPTH)` bits. Count is `$clog2(FIFO_DEPTH)+1` bits, so full = count==FIFO_DEPTH.
- **Unaligned addresses:** not decoded; `sel`=0.

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0, `uart_tx`=1, `busy`=0, FSM=IDLE, FIFO empty, counters 0.
- **Bus latency:** request at cycle N leads to `mem_ready`=1 at N+1 (no stall).
- **Start-bit latency:** the push takes effect at the end of N. With the FSM in IDLE, the pop occurs at the end of N+1, and `uart_tx` falls at N+2.
- **Frame length:** exactly `10*CLK_DIV` cycles. Back-to-back frames are contiguous.
- **`busy`:** registered; rises the cycle after the first push; falls the cycle after the last STOP bit ends with FIFO empty.
- **Reset mid-frame:** the next edge forces `uart_tx`=1, IDLE, and FIFO flushed. A pending `mem_ready` is dropped.
- **`mem_rdata` between acks:** held at 0 when `mem_ready`=0.

## Test plan
- **Single char:** `CLK_DIV`=4, write `0x41` to `ADDR_DATA`. Expect `mem_ready` for 1 cycle at N+1. `uart_tx` starts at N+2 with bits 0,1,0,0,0,0,0,1,0,1, each 4 cycles (40 total), then stays high; `busy` falls after.
- **Back-to-back:** write `0x55` then `0xAA`. Expect two contiguous 40-cycle frames with no idle bit between them, LSB first.
- **Full stall:** `FIFO_DEPTH`=16, write 18 chars back-to-back.
  - Writes 1–17 are acked without stall (one char in the shifter, 16 in the FIFO).
  - Write 18's `mem_ready` is held low until the second char is popped at the end of the first frame's STOP, then acked next cycle.
  - All 18 chars are serialized in order.
- **Status reads:**
  - Idle read of `ADDR_STAT` returns `0x0000_0002`.
  - With 3 chars queued while the shifter is active, it returns `0x0000_0304`.
  - A read of `ADDR_DATA` returns 0.
- **Decode and strobes:** a write to `0x1000_0008` gives `sel`=0 and no `mem_ready`. A write to `ADDR_DATA` with `wstrb`=`4'b0010` is acked and the FIFO count is unchanged.
- **Reset mid-frame:** assert `resetn`=0 during DATA bit 3 with 2 chars queued. Expect `uart_tx`=1 the next cycle and stat=`0x0000_0002` after release, with no further frames.

Source files
------------

// File: rtl/console_uart_tx.sv
// console_uart_tx: memory-mapped console sink for the picorv32 native bus.
//
// CPU stores to ADDR_DATA push a character into a small FIFO; a serializer
// drains the FIFO as 8N1 UART frames on uart_tx. ADDR_STAT returns FIFO and
// shifter status. Both registers answer with a one-cycle registered mem_ready.
//
// Bus handshake: a request is taken in a cycle where sel=1 and mem_ready=0,
// unless it is a data write while the FIFO is full and nothing is popped in
// that same cycle, in which case mem_ready stays low and the request is
// retried each cycle until space appears. mem_ready is high for exactly one
// cycle after the request is taken. mem_rdata is meaningful only while
// mem_ready=1 and is forced to zero otherwise.

module console_uart_tx #(
  parameter logic [31:0] ADDR_DATA  = 32'h1000_0000,
  parameter logic [31:0] ADDR_STAT  = 32'h1000_0004,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        busy
);

  // Baud counter width; CLK_DIV >= 2 keeps this at least one bit.
  localparam int BW = $clog2(CLK_DIV);
  // FIFO pointer width (pointers wrap naturally) and occupancy width.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Serializer state
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  // FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;

  // Bus response state
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  // Decode / control
  logic          hit_data;
  logic          hit_stat;
  logic          is_write;
  logic          accept;
  logic          push;
  logic          pop;
  logic          baud_done;
  logic [31:0]   stat_word;

  // Only the low byte of the write data is a character.
  logic          unused_wdata;
  assign unused_wdata = ^mem_wdata[31:8];

  assign fifo_full    = (count_q == COUNT_FULL);
  assign fifo_empty   = (count_q == '0);
  assign fifo_rd_data = fifo_mem[rd_ptr_q];

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;
  assign busy      = busy_q;

  // Address decode, accept/stall decision and status word assembly.
  always_comb begin
    hit_data  = (mem_addr == ADDR_DATA);
    hit_stat  = (mem_addr == ADDR_STAT);
    is_write  = (mem_wstrb != 4'b0000);
    sel       = mem_valid && (hit_data || hit_stat);
    // A data write into a full FIFO waits, but a pop in the same cycle
    // frees the slot it needs, so it goes through immediately.
    accept    = sel && !ready_q && !(hit_data && is_write && fifo_full && !pop);
    push      = accept && hit_data && mem_wstrb[0];
    stat_word = {16'h0000, 8'(count_q), 5'b00000,
                 (state_q != S_IDLE), fifo_empty, fifo_full};
  end

  // Registered one-cycle acknowledge and read data (zero unless a read is acked).
  always_comb begin
    ready_d = accept;
    rdata_d = '0;
    if (accept && !is_write && hit_stat) begin
      rdata_d = stat_word;
    end
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer next state: every state or bit change reloads the baud counter.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    baud_done = (baud_q == '0);

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rd_data;
          state_d = S_START;
          baud_d  = BAUD_RELOAD;
        end
      end

      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          shreg_d = {1'b0, shreg_q[7:1]};
          // The bit counter wraps 7 -> 0 on the way out, ready for the next frame.
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          // Chain straight into the next start bit so frames are contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_rd_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level and busy are registered from next-state values so the pin is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  // All control state; synchronous active-low reset flushes FIFO and drops any pending ack.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  // Character storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Testbench for console_uart_tx: directed scenarios plus randomized bus
// traffic. Characters written to the data register are queued in exp_q;
// a line monitor decodes every UART frame cycle by cycle and compares it
// against the head of that queue.

module tb_console_uart_tx;

  localparam int          CLK_DIV    = 4;
  localparam int          FIFO_DEPTH = 16;
  localparam int          FRAME      = 10 * CLK_DIV;
  localparam logic [31:0] A_DATA     = 32'h1000_0000;
  localparam logic [31:0] A_STAT     = 32'h1000_0004;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        sel;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         start_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  console_uart_tx #(
    .ADDR_DATA (A_DATA),
    .ADDR_STAT (A_STAT),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .sel      (sel),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .uart_tx  (uart_tx),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus transfer starting on the next cycle; returns read data, latency and request cycle.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output int lat, output int req_c);
    @(posedge clk); #1;
    req_c     = cyc;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (addr == A_DATA && wstrb[0]) exp_q.push_back(wdata[7:0]);
    #1 check("sel_decode", {31'b0, sel}, 32'd1);
    lat   = 0;
    rdata = '0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready === 1'b1) begin
        rdata = mem_rdata;
        break;
      end
      if (lat >= 300) begin
        check("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  // A request to an undecoded address must not select or acknowledge.
  task automatic bus_nosel(input logic [31:0] addr, input logic [3:0] wstrb);
    logic seen;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = 32'h0000_005a;
    mem_wstrb = wstrb;
    #1 check("sel_nodecode", {31'b0, sel}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready !== 1'b0) seen = 1'b1;
    end
    check("nosel_no_ready", {31'b0, seen}, 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (start_log.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("frame_start_seen", {31'b0, start_log.size() >= n}, 32'd1);
  endtask

  // ---------------- scoreboard / line monitor ----------------
  logic       in_frame = 1'b0;
  logic       skip_frame = 1'b0;
  logic       frame_bad = 1'b0;
  logic       prev_ready = 1'b0;
  logic [9:0] cur_frame = '0;
  logic [9:0] act_frame = '0;
  int         fpos = 0;

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && !in_frame) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_idle", {31'b0, k < budget}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      in_frame   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (mem_ready === 1'b1) check("ready_one_cycle", {31'b0, prev_ready}, 32'd0);
      else                    check("rdata_zero_between_acks", mem_rdata, 32'd0);
      prev_ready = (mem_ready === 1'b1);

      if (!in_frame && uart_tx === 1'b0) begin
        in_frame  = 1'b1;
        fpos      = 0;
        act_frame = '0;
        frame_bad = 1'b0;
        start_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          skip_frame = 1'b1;
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          skip_frame = 1'b0;
          cur_frame  = {1'b1, exp_q.pop_front(), 1'b0};
        end
      end

      if (in_frame) begin
        if (!skip_frame && uart_tx !== cur_frame[fpos / CLK_DIV]) frame_bad = 1'b1;
        if (fpos % CLK_DIV == CLK_DIV / 2) act_frame[fpos / CLK_DIV] = uart_tx;
        fpos++;
        if (fpos == FRAME) begin
          in_frame = 1'b0;
          if (!skip_frame)
            check("uart_frame", {21'b0, frame_bad, act_frame}, {22'b0, cur_frame});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    logic [3:0]  ws;
    int          lat;
    int          rq;
    int          s0;
    int          op;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_sel", {31'b0, sel}, 32'd0);
    resetn = 1'b1;

    // Single character: ack at N+1, start bit at N+2, busy drops after 40 cycles.
    start_log.delete();
    bus_xfer(A_DATA, 32'h0000_0041, 4'b0001, rd, lat, rq);
    check("single_ack_latency", lat, 32'd1);
    check("busy_after_push", {31'b0, busy}, 32'd1);
    wait_frames(1, 20);
    if (start_log.size() > 0) begin
      check("start_bit_latency", start_log[0] - rq, 32'd2);
      wait_cycle(start_log[0] + FRAME - 1);
      check("busy_in_stop", {31'b0, busy}, 32'd1);
      check("tx_in_stop", {31'b0, uart_tx}, 32'd1);
      wait_cycle(start_log[0] + FRAME);
      check("busy_after_frame", {31'b0, busy}, 32'd0);
      check("tx_idle_after_frame", {31'b0, uart_tx}, 32'd1);
    end
    wait_idle(200);

    // Back-to-back frames must be contiguous.
    start_log.delete();
    bus_xfer(A_DATA, 32'h0000_0055, 4'b1111, rd, lat, rq);
    bus_xfer(A_DATA, 32'h0000_00aa, 4'b0001, rd, lat, rq);
    wait_idle(300);
    check("b2b_frame_count", start_log.size(), 32'd2);
    if (start_log.size() == 2) check("b2b_contiguous", start_log[1] - start_log[0], FRAME);

    // Status reads.
    bus_xfer(A_STAT, 32'h0, 4'b0000, rd, lat, rq);
    check("stat_idle", rd, 32'h0000_0002);
    bus_xfer(A_DATA, 32'h0, 4'b0000, rd, lat, rq);
    check("data_read_zero", rd, 32'h0);
    for (int i = 0; i < 4; i++) bus_xfer(A_DATA, 32'h30 + i, 4'b0001, rd, lat, rq);
    bus_xfer(A_STAT, 32'h0, 4'b0000, rd, lat, rq);
    check("stat_three_queued", rd, 32'h0000_0304);
    wait_idle(400);

    // Decode and strobes.
    bus_nosel(32'h1000_0008, 4'b1111);
    bus_nosel(A_DATA + 32'd1, 4'b0001);
    bus_xfer(A_DATA, 32'h0000_0077, 4'b0010, rd, lat, rq);
    check("nopush_ack_latency", lat, 32'd1);
    bus_xfer(A_STAT, 32'hffff_ffff, 4'b1111, rd, lat, rq);
    check("stat_write_ack_latency", lat, 32'd1);
    bus_xfer(A_STAT, 32'h0, 4'b0000, rd, lat, rq);
    check("stat_after_nopush", rd, 32'h0000_0002);

    // Full-FIFO stall: 17 writes unstalled, the 18th waits for the first STOP to end.
    start_log.delete();
    for (int i = 0; i < 18; i++) begin
      bus_xfer(A_DATA, $urandom_range(0, 255), 4'b0001, rd, lat, rq);
      if (i < 17) check("fill_ack_latency", lat, 32'd1);
      else if (start_log.size() > 0) check("stall_ack_cycle", rq + lat, start_log[0] + FRAME + 1 - 1);
      else check("stall_first_frame_started", 32'd0, 32'd1);
    end
    wait_idle(2000);
    check("stall_frame_count", start_log.size(), 32'd18);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (op <= 4) begin
        ws = {3'($urandom_range(0, 7)), 1'b1};
        bus_xfer(A_DATA, $urandom, ws, rd, lat, rq);
      end else if (op == 5) begin
        ws = 4'($urandom_range(1, 7) << 1);
        bus_xfer(A_DATA, $urandom, ws, rd, lat, rq);
      end else if (op == 6) begin
        bus_xfer(A_DATA, $urandom, 4'b0000, rd, lat, rq);
        check("rand_data_read_zero", rd, 32'h0);
      end else if (op == 7) begin
        bus_xfer(A_STAT, $urandom, 4'b0000, rd, lat, rq);
        check("rand_stat_reserved_zero", {rd[31:16], 11'b0, rd[7:3]}, 32'h0);
        check("rand_stat_full_flag", {31'b0, rd[0]}, {31'b0, rd[15:8] == FIFO_DEPTH});
        check("rand_stat_empty_flag", {31'b0, rd[1]}, {31'b0, rd[15:8] == 0});
        check("rand_stat_count_range", {31'b0, rd[15:8] <= FIFO_DEPTH}, 32'd1);
      end else if (op == 8) begin
        bus_xfer(A_STAT, $urandom, 4'b1111, rd, lat, rq);
        check("rand_stat_write_ack", lat, 32'd1);
      end else begin
        case ($urandom_range(0, 3))
          0:       addr = A_DATA + 32'($urandom_range(1, 3));
          1:       addr = A_STAT + 32'($urandom_range(1, 3));
          2:       addr = 32'h1000_0008;
          default: addr = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
        endcase
        bus_nosel(addr, 4'($urandom_range(0, 15)));
      end
    end
    wait_idle(5000);
    bus_xfer(A_STAT, 32'h0, 4'b0000, rd, lat, rq);
    check("stat_idle_after_random", rd, 32'h0000_0002);

    // Reset during data bit 3 with two characters still queued.
    start_log.delete();
    bus_xfer(A_DATA, 32'h31, 4'b0001, rd, lat, rq);
    bus_xfer(A_DATA, 32'h32, 4'b0001, rd, lat, rq);
    bus_xfer(A_DATA, 32'h33, 4'b0001, rd, lat, rq);
    wait_frames(1, 20);
    if (start_log.size() > 0) begin
      s0 = start_log[0];
      wait_cycle(s0 + 1 * CLK_DIV + 3 * CLK_DIV + 1);
      resetn = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      check("midreset_tx_high", {31'b0, uart_tx}, 32'd1);
      check("midreset_busy_low", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      bus_xfer(A_STAT, 32'h0, 4'b0000, rd, lat, rq);
      check("stat_after_midreset", rd, 32'h0000_0002);
      repeat (5 * FRAME) @(posedge clk);
      #1;
      check("no_frames_after_reset", start_log.size(), 32'd1);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("monitor_idle", {31'b0, in_frame}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time bound at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
